// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch stage feeding a single-entry IF/ID register.
//
// Holds the program counter and fetches one word per cycle from a
// combinational instruction RAM. Misaligned or out-of-range addresses
// produce a fault entry (NOP encoding, if_fault=1), and fetch then stops
// until a redirect arrives.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous active-high reset
//   fetch_en       : fetch gate (low while the instruction RAM is loaded)
//   inst_addr      : byte address to the instruction RAM (always pc)
//   inst_dout      : instruction word for inst_addr (combinational)
//   redirect_valid : branch/jump/trap redirect request
//   redirect_pc    : new fetch address, used when redirect_valid=1
//   if_valid       : IF/ID register holds an entry
//   if_ready       : decode accepts the IF/ID entry this cycle
//   if_pc          : byte address of the held entry
//   if_inst        : held instruction word
//   if_fault       : held entry is a fetch fault
//   fetch_cnt      : wrapping count of accepted transfers
// ----------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IRAM_BYTES = 32764
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] IRAM_LIMIT = 32'(IRAM_BYTES);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        if_valid_nx;
    logic [31:0] if_pc_nx;
    logic [31:0] if_inst_nx;
    logic        if_fault_nx;
    logic [31:0] fetch_cnt_nx;

    logic bad_pc;
    logic slot_free;
    logic fire;
    logic accept;

    assign inst_addr = pc;
    assign bad_pc    = (pc[1:0] != 2'b00) || (pc >= IRAM_LIMIT);
    assign slot_free = !if_valid || if_ready;
    assign fire      = (state == RUN) && fetch_en && slot_free && !redirect_valid;
    assign accept    = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_inst   <= NOP_INST;
            if_fault  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            if_valid  <= if_valid_nx;
            if_pc     <= if_pc_nx;
            if_inst   <= if_inst_nx;
            if_fault  <= if_fault_nx;
            fetch_cnt <= fetch_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        if_valid_nx  = if_valid;
        if_pc_nx     = if_pc;
        if_inst_nx   = if_inst;
        if_fault_nx  = if_fault;
        fetch_cnt_nx = fetch_cnt;

        // A transfer completes whenever valid and ready meet, even in the
        // same cycle as a redirect that flushes the register.
        if (accept) begin
            fetch_cnt_nx = fetch_cnt + 32'd1;
        end

        if (redirect_valid) begin
            pc_nx       = redirect_pc;
            if_valid_nx = 1'b0;
            state_nx    = RUN;
        end else if (fire) begin
            if_valid_nx = 1'b1;
            if_pc_nx    = pc;
            if (bad_pc) begin
                // pc is held so the fault entry names the offending address;
                // only a redirect restarts fetch.
                if_inst_nx  = NOP_INST;
                if_fault_nx = 1'b1;
                state_nx    = FAULT;
            end else begin
                if_inst_nx  = inst_dout;
                if_fault_nx = 1'b0;
                pc_nx       = pc + 32'd4;
            end
        end else if (accept) begin
            if_valid_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- directed self-checking bench for ifetch (default parameters).
// Instruction RAM: words A..D at byte addresses 0..12, every other address
// returns {16'hBEEF, addr[15:0]}.
// ----------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] W_A = 32'h0010_0093;
    localparam logic [31:0] W_B = 32'h0020_0113;
    localparam logic [31:0] W_C = 32'h0020_81B3;
    localparam logic [31:0] W_D = 32'h4011_0233;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;
    logic [31:0] fetch_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ifetch #(
        .RESET_PC   (32'h0000_0000),
        .IRAM_BYTES (32764)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .inst_addr      (inst_addr),
        .inst_dout      (inst_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (inst_addr)
            32'h0:   inst_dout = W_A;
            32'h4:   inst_dout = W_B;
            32'h8:   inst_dout = W_C;
            32'hC:   inst_dout = W_D;
            default: inst_dout = {16'hBEEF, inst_addr[15:0]};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input logic v, input logic [31:0] p,
                             input logic [31:0] i, input logic f);
        chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
        chk({tag, ".pc"},    if_pc, p);
        chk({tag, ".inst"},  if_inst, i);
        chk({tag, ".fault"}, {31'b0, if_fault}, {31'b0, f});
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        chk_entry("reset", 1'b0, 32'h0, NOP, 1'b0);
        chk("reset.cnt", fetch_cnt, 32'd0);
        chk("reset.addr", inst_addr, 32'h0);

        // Streaming A,B,C,D then drain with fetch_en low
        rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        step(); chk_entry("s0", 1'b1, 32'h0, W_A, 1'b0); chk("s0.addr", inst_addr, 32'h4);
        step(); chk_entry("s1", 1'b1, 32'h4, W_B, 1'b0); chk("s1.cnt", fetch_cnt, 32'd1);
        step(); chk_entry("s2", 1'b1, 32'h8, W_C, 1'b0);
        step(); chk_entry("s3", 1'b1, 32'hC, W_D, 1'b0); chk("s3.cnt", fetch_cnt, 32'd3);
        fetch_en = 1'b0;
        step(); chk("drain.valid", {31'b0, if_valid}, 32'd0);
        chk("drain.cnt", fetch_cnt, 32'd4); chk("drain.addr", inst_addr, 32'h10);

        // Backpressure at if_pc=8
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(); chk("bp.redir.addr", inst_addr, 32'h0);
        redirect_valid = 1'b0; fetch_en = 1'b1;
        step(); step(); step();
        chk_entry("bp.pre", 1'b1, 32'h8, W_C, 1'b0); chk("bp.pre.cnt", fetch_cnt, 32'd6);
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_entry("bp.hold", 1'b1, 32'h8, W_C, 1'b0);
            chk("bp.hold.addr", inst_addr, 32'hC);
            chk("bp.hold.cnt", fetch_cnt, 32'd6);
        end
        if_ready = 1'b1;
        step(); chk_entry("bp.resume", 1'b1, 32'hC, W_D, 1'b0); chk("bp.resume.cnt", fetch_cnt, 32'd7);

        // Redirect while stalled
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); chk("rd.valid", {31'b0, if_valid}, 32'd0);
        chk("rd.addr", inst_addr, 32'h40); chk("rd.cnt", fetch_cnt, 32'd7);
        redirect_valid = 1'b0; if_ready = 1'b1;
        step(); chk_entry("rd.first", 1'b1, 32'h40, 32'hBEEF_0040, 1'b0);

        // Redirect to misaligned 0x42 in the same cycle as an accept
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(); chk("flt.redir.cnt", fetch_cnt, 32'd8); chk("flt.redir.valid", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b0; if_ready = 1'b0;
        step(); chk_entry("flt.entry", 1'b1, 32'h42, NOP, 1'b1); chk("flt.addr", inst_addr, 32'h42);
        step(); chk_entry("flt.hold", 1'b1, 32'h42, NOP, 1'b1);
        if_ready = 1'b1;
        step(); chk("flt.acc.valid", {31'b0, if_valid}, 32'd0); chk("flt.acc.cnt", fetch_cnt, 32'd9);
        step(); chk("flt.idle.valid", {31'b0, if_valid}, 32'd0); chk("flt.idle.addr", inst_addr, 32'h42);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step(); chk("flt.rec.addr", inst_addr, 32'h10);
        redirect_valid = 1'b0;
        step(); chk_entry("flt.rec", 1'b1, 32'h10, 32'hBEEF_0010, 1'b0);

        // Upper range boundary
        redirect_valid = 1'b1; redirect_pc = 32'd32760;
        step(); chk("rng.redir.cnt", fetch_cnt, 32'd10); chk("rng.redir.addr", inst_addr, 32'd32760);
        redirect_valid = 1'b0;
        step(); chk_entry("rng.last", 1'b1, 32'd32760, 32'hBEEF_7FF8, 1'b0);
        chk("rng.last.addr", inst_addr, 32'd32764);
        step(); chk_entry("rng.over", 1'b1, 32'd32764, NOP, 1'b1);
        chk("rng.over.cnt", fetch_cnt, 32'd11); chk("rng.over.addr", inst_addr, 32'd32764);

        // Reset while stalled in FAULT with a redirect pending
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; rst = 1'b1;
        step(); chk_entry("rst2", 1'b0, 32'h0, NOP, 1'b0);
        chk("rst2.cnt", fetch_cnt, 32'd0); chk("rst2.addr", inst_addr, 32'h0);
        rst = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1; fetch_en = 1'b0;
        step(); chk("rst2.gated", {31'b0, if_valid}, 32'd0);
        fetch_en = 1'b1;
        step(); chk_entry("rst2.run", 1'b1, 32'h0, W_A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
